// File: rtl/imm_gen_stream.sv
// -----------------------------------------------------------------------------
// imm_gen_stream
//
// Immediate generator for the RV base instruction formats (I, S, B, U, J),
// placed between fetch/decode and the ALU/AGU. Every accepted instruction
// yields one result {offset, fmt, imm_valid}. Results stream out through a
// 2-entry skid FIFO, strictly in acceptance order. Instructions with an
// unrecognised opcode still produce a result (offset 0, fmt NONE,
// imm_valid 0), so the result stream stays aligned with the instruction
// stream.
//
// Parameters
//   XLEN        result width, 32 or 64
//   INST_WIDTH  instruction width, 32 only
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   flush        in   synchronous flush: drops every buffered result and any
//                     instruction offered in the same cycle
//   in_valid     in   instruction valid
//   in_ready     out  block can accept an instruction this cycle
//   instruction  in   raw instruction word
//   out_valid    out  head result valid
//   out_ready    in   consumer accepts the head result
//   offset       out  sign-extended immediate (0 when no result is held)
//   fmt          out  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//   imm_valid    out  opcode recognised (fmt != NONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload unchanged until the
// transfer. in_ready comes only from registered state (count != 2) and never
// depends on out_ready, so there is no combinational path from the consumer
// back to the producer. The head result stays stable while out_valid is high
// and out_ready is low.
// -----------------------------------------------------------------------------
module imm_gen_stream #(
  parameter int XLEN       = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       offset,
  output logic [2:0]            fmt,
  output logic                  imm_valid
);

  // Format tags.
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  // Major opcodes, instruction[6:0].
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  // OP-IMM-32 (addiw and friends) exists only on RV64.
  localparam bit RV64 = (XLEN == 64);

  // FIFO depth is fixed at two entries.
  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  // ---------------------------------------------------------------------------
  // Decode (combinational on the incoming instruction)
  // ---------------------------------------------------------------------------
  logic [6:0]        opcode;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  logic [XLEN-1:0]   dec_offset;
  logic [2:0]        dec_fmt;
  logic              dec_imm_valid;

  assign opcode = instruction[6:0];

  // Raw immediates at their natural width. Declaring them signed makes the
  // size casts below replicate each format's MSB up to XLEN. The U
  // immediate is already 32 bits, so it only widens when XLEN is 64.
  assign imm_i = instruction[31:20];
  assign imm_s = {instruction[31:25], instruction[11:7]};
  assign imm_b = {instruction[31], instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {instruction[31], instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};

  always_comb begin
    dec_offset = '0;
    dec_fmt    = FMT_NONE;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        dec_offset = XLEN'(imm_i);
        dec_fmt    = FMT_I;
      end
      OPC_OP_IMM_32: begin
        if (RV64) begin
          dec_offset = XLEN'(imm_i);
          dec_fmt    = FMT_I;
        end
      end
      OPC_STORE: begin
        dec_offset = XLEN'(imm_s);
        dec_fmt    = FMT_S;
      end
      OPC_BRANCH: begin
        dec_offset = XLEN'(imm_b);
        dec_fmt    = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_offset = XLEN'(imm_u);
        dec_fmt    = FMT_U;
      end
      OPC_JAL: begin
        dec_offset = XLEN'(imm_j);
        dec_fmt    = FMT_J;
      end
      default: begin
        dec_offset = '0;
        dec_fmt    = FMT_NONE;
      end
    endcase
  end

  assign dec_imm_valid = (dec_fmt != FMT_NONE);

  // ---------------------------------------------------------------------------
  // 2-entry result FIFO
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] buf_offset [2];
  logic [2:0]      buf_fmt    [2];
  logic            buf_iv     [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic [1:0]      count_nxt;
  logic            push;
  logic            pop;

  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != CNT_EMPTY);

  // A flush cancels any push offered in the same cycle, so the offered
  // instruction never produces a result.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;  // idle, or push and pop together
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= CNT_EMPTY;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      buf_offset[0] <= '0;
      buf_offset[1] <= '0;
      buf_fmt[0]    <= FMT_NONE;
      buf_fmt[1]    <= FMT_NONE;
      buf_iv[0]     <= 1'b0;
      buf_iv[1]     <= 1'b0;
    end else if (flush) begin
      // Storage contents do not matter once count is zero. The output mux
      // forces the result fields to zero while the FIFO is empty.
      count  <= CNT_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        buf_offset[wr_ptr] <= dec_offset;
        buf_fmt[wr_ptr]    <= dec_fmt;
        buf_iv[wr_ptr]     <= dec_imm_valid;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_nxt;
    end
  end

  // Head result. The fields are zero whenever no result is held.
  assign offset    = out_valid ? buf_offset[rd_ptr] : '0;
  assign fmt       = out_valid ? buf_fmt[rd_ptr]    : FMT_NONE;
  assign imm_valid = out_valid ? buf_iv[rd_ptr]     : 1'b0;

endmodule

// File: tb/tb_imm_gen_stream.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stream
//
// Directed bench for imm_gen_stream. One XLEN=32 instance and one XLEN=64
// instance share clk and rst. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge, so each check sees the state
// left by the preceding rising edge.
// -----------------------------------------------------------------------------
module tb_imm_gen_stream;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // XLEN=32 instance signals
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] offset;
  logic [2:0]  fmt;
  logic        imm_valid;

  // XLEN=64 instance signals
  logic        w_flush;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_instruction;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_offset;
  logic [2:0]  w_fmt;
  logic        w_imm_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];

  imm_gen_stream #(.XLEN(32), .INST_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .offset(offset), .fmt(fmt), .imm_valid(imm_valid)
  );

  imm_gen_stream #(.XLEN(64), .INST_WIDTH(32)) dut64 (
    .clk(clk), .rst(rst), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .instruction(w_instruction),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .offset(w_offset), .fmt(w_fmt), .imm_valid(w_imm_valid)
  );

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || offset !== 32'h0 || fmt !== 3'd0 || imm_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b off=%h fmt=%0d iv=%b required all 0",
               out_valid, offset, fmt, imm_valid);
    end
    n_cmp++;
    if (w_out_valid !== 1'b0 || w_offset !== 64'h0) begin
      n_err++;
      $display("FAIL reset_outputs64: got v=%b off=%h required 0", w_out_valid, w_offset);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One instruction at a time through the XLEN=32 instance.
  task automatic test_decode32();
    logic [31:0] vin  [11];
    logic [31:0] vexp [11];
    logic [2:0]  vfmt [11];
    vin  = '{32'hFFC12083, 32'hFE000CE3, 32'h123450B7, 32'h0010006F, 32'h0000007F,
             32'hFE112E23, 32'h00008067, 32'h00001017, 32'h00000463, 32'hFFDFF06F,
             32'h0010009B};
    vexp = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800, 32'h00000000,
             32'hFFFFFFFC, 32'h00000000, 32'h00001000, 32'h00000008, 32'hFFFFFFFC,
             32'h00000000};
    vfmt = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd0, 3'd2, 3'd1, 3'd4, 3'd3, 3'd5, 3'd0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      instruction = vin[i];
      out_ready   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || offset !== vexp[i] || fmt !== vfmt[i] ||
          imm_valid !== (vfmt[i] != 3'd0)) begin
        n_err++;
        $display("FAIL decode32[%0d] %h: got v=%b off=%h fmt=%0d iv=%b required v=1 off=%h fmt=%0d",
                 i, vin[i], out_valid, offset, fmt, imm_valid, vexp[i], vfmt[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || offset !== 32'h0) begin
      n_err++;
      $display("FAIL decode32_drain: got v=%b off=%h required 0/0", out_valid, offset);
    end
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    // addi x1,x0,1 / 2 / 3
    @(negedge clk);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h00100093;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready0: got %b required 1", in_ready);
    end
    @(negedge clk);
    instruction = 32'h00200093;
    n_cmp++;
    if (in_ready !== 1'b1 || offset !== 32'd1) begin
      n_err++; $display("FAIL bp_one: got rdy=%b off=%h required 1/1", in_ready, offset);
    end
    @(negedge clk);
    instruction = 32'h00300093;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || offset !== 32'd1) begin
      n_err++; $display("FAIL bp_full: got rdy=%b v=%b off=%h required 0/1/1", in_ready, out_valid, offset);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || offset !== 32'd1 || fmt !== 3'd1) begin
      n_err++; $display("FAIL bp_hold: got rdy=%b off=%h fmt=%0d required 0/1/1", in_ready, offset, fmt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || offset !== 32'd2) begin
      n_err++; $display("FAIL bp_pop1: got rdy=%b v=%b off=%h required 1/1/2", in_ready, out_valid, offset);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || offset !== 32'd3) begin
      n_err++; $display("FAIL bp_pop2: got v=%b off=%h required 1/3", out_valid, offset);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_empty: got v=%b required 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int got;
    got = 0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c <= 16) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL stream_ready[%0d]: got %b required 1", c, in_ready);
        end
      end
      if (c >= 1 && c <= 16) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_err++; $display("FAIL stream_valid[%0d]: got %b required 1", c, out_valid);
        end
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stream_extra[%0d]: got off=%h required none", c, offset);
        end else begin
          if (offset !== exp_q[0]) begin
            n_err++; $display("FAIL stream_data[%0d]: got %h required %h", c, offset, exp_q[0]);
          end
          void'(exp_q.pop_front());
          got++;
        end
      end
      if (c < 16) begin
        in_valid    = 1'b1;
        instruction = {12'(c + 100), 13'b0, 7'b0010011};
        exp_q.push_back(32'(c + 100));
      end else begin
        in_valid = 1'b0;
      end
    end
    n_cmp++;
    if (got != 16) begin
      n_err++; $display("FAIL stream_count: got %0d required 16", got);
    end
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    // Fill to two entries.
    @(negedge clk);
    in_valid = 1'b1; instruction = 32'h00100093;
    @(negedge clk);
    instruction = 32'h00200093;
    @(negedge clk);
    instruction = 32'h00300093;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || offset !== 32'h0) begin
      n_err++; $display("FAIL flush_full: got v=%b rdy=%b off=%h required 0/1/0", out_valid, in_ready, offset);
    end
    // One entry held, flush with an accepted-looking push: both discarded.
    @(negedge clk);
    in_valid = 1'b1; instruction = 32'h00400093;
    @(negedge clk);
    instruction = 32'h00500093; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_one: got v=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_no_emit: got v=%b off=%h required 0", out_valid, offset);
    end
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; instruction = 32'hFFC12083;
    @(negedge clk);
    instruction = 32'h123450B7;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || offset !== 32'h0 || fmt !== 3'd0 || imm_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_async: got v=%b off=%h fmt=%0d iv=%b required all 0",
                        out_valid, offset, fmt, imm_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_release: got rdy=%b v=%b required 1/0", in_ready, out_valid);
    end
    in_valid = 1'b1; instruction = 32'hFE000CE3;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || offset !== 32'hFFFFFFF8 || fmt !== 3'd3) begin
      n_err++; $display("FAIL reset_mid_resume: got v=%b off=%h fmt=%0d required 1/fffffff8/3",
                        out_valid, offset, fmt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_decode64();
    logic [31:0] vin  [4];
    logic [63:0] vexp [4];
    logic [2:0]  vfmt [4];
    vin  = '{32'hFFC12083, 32'h800000B7, 32'h0010009B, 32'hFFDFF06F};
    vexp = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h1, 64'hFFFFFFFFFFFFFFFC};
    vfmt = '{3'd1, 3'd4, 3'd1, 3'd5};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_in_valid    = 1'b1;
      w_instruction = vin[i];
      w_out_ready   = 1'b1;
      @(negedge clk);
      w_in_valid = 1'b0;
      n_cmp++;
      if (w_out_valid !== 1'b1 || w_offset !== vexp[i] || w_fmt !== vfmt[i] || w_imm_valid !== 1'b1) begin
        n_err++;
        $display("FAIL decode64[%0d] %h: got v=%b off=%h fmt=%0d iv=%b required v=1 off=%h fmt=%0d iv=1",
                 i, vin[i], w_out_valid, w_offset, w_fmt, w_imm_valid, vexp[i], vfmt[i]);
      end
    end
    @(negedge clk);
    w_out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    flush = 1'b0; in_valid = 1'b0; instruction = 32'h0; out_ready = 1'b0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_instruction = 32'h0; w_out_ready = 1'b0;
    test_reset();
    test_decode32();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_decode64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
